// File: rtl/prog_loader.sv
// prog_loader: fills the 16 x 32-bit program memory from a checksummed byte
// stream and holds the processor core in reset until the image is verified.
// Stream: header N, then N big-endian words, then the XOR of all payload bytes.
module prog_loader #(
    parameter int INST_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [INST_W-1:0] im_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int             BPW     = INST_W / 8;
    localparam int             BCNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [8:0]     DEPTH_B = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rdy;
    logic [ADDR_W:0]     r_n;
    logic [ADDR_W:0]     r_widx;
    logic [INST_W-1:0]   r_word;
    logic [7:0]          r_csum;
    logic [BCNT_W-1:0]   r_bcnt;

    logic                w_acc;
    logic                w_last_byte;
    logic                w_hdr_ok;
    logic [ADDR_W:0]     w_widx_inc;

    // A byte is consumed only when the handshake completes and no reload is pending
    assign w_acc       = rx_valid & r_rdy & ~reload;
    assign w_last_byte = (r_bcnt == BCNT_W'(BPW - 1));
    assign w_hdr_ok    = (rx_data != 8'd0) && ({1'b0, rx_data} <= DEPTH_B);
    assign w_widx_inc  = r_widx + 1'b1;

    // Next-state decode; reload overrides every state
    always_comb begin
        w_state_nxt = r_state;
        if (reload) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_acc) w_state_nxt = w_hdr_ok ? S_RECV : S_ERR;
                S_RECV:  if (w_acc && w_last_byte) w_state_nxt = S_WRITE;
                S_WRITE: w_state_nxt = (w_widx_inc == r_n) ? S_CHECK : S_RECV;
                S_CHECK: if (w_acc) w_state_nxt = (rx_data == r_csum) ? S_DONE : S_ERR;
                S_DONE:  w_state_nxt = S_DONE;
                S_ERR:   w_state_nxt = S_ERR;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register; rx_ready is registered from the next state so it stays low in reset
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RECV) ||
                       (w_state_nxt == S_CHECK);
        end
    end

    // Word assembly, running checksum, byte counter and word index
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_n    <= '0;
            r_widx <= '0;
            r_word <= '0;
            r_csum <= '0;
            r_bcnt <= '0;
        end else if (reload) begin
            r_widx <= '0;
            r_csum <= '0;
            r_bcnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc && w_hdr_ok) r_n <= rx_data[ADDR_W:0];
                end
                S_RECV: begin
                    if (w_acc) begin
                        r_word <= (r_word << 8) | INST_W'(rx_data);
                        r_csum <= r_csum ^ rx_data;
                        r_bcnt <= w_last_byte ? '0 : r_bcnt + 1'b1;
                    end
                end
                S_WRITE: r_widx <= w_widx_inc;
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only
    assign rx_ready     = r_rdy;
    assign im_we        = (r_state == S_WRITE);
    assign im_addr      = r_widx[ADDR_W-1:0];
    assign im_wdata     = r_word;
    assign cpu_rst      = (r_state != S_DONE);
    assign load_done    = (r_state == S_DONE);
    assign load_err     = (r_state == S_ERR);
    assign words_loaded = r_widx;

endmodule
